// File: rtl/sd_cmd_sequencer_pkg.sv
// ============================================================================
// Module : sd_cmd_sequencer_pkg
// Brief  : Shared SD controller register map, field sizes and sequencer states.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifndef SD_DEFINES_SVH
`define SD_DEFINES_SVH
`define ARGUMENT     8'h00
`define COMMAND      8'h04
`define RESP0        8'h08
`define RESP1        8'h0c
`define RESP2        8'h10
`define RESP3        8'h14
`define CMD_ISR      8'h34
`define CMD_REG_SIZE 14
`define INT_CMD_SIZE 5
`define INT_CMD_CC   0
`define INT_CMD_EI   1
`endif

package sd_cmd_sequencer_pkg;

    localparam int c_cmd_reg_size = `CMD_REG_SIZE;
    localparam int c_int_cmd_size = `INT_CMD_SIZE;
    localparam int c_int_cmd_cc   = `INT_CMD_CC;
    localparam int c_int_cmd_ei   = `INT_CMD_EI;

    localparam logic [7:0] c_adr_argument = `ARGUMENT;
    localparam logic [7:0] c_adr_command  = `COMMAND;
    localparam logic [7:0] c_adr_resp0    = `RESP0;
    localparam logic [7:0] c_adr_resp1    = `RESP1;
    localparam logic [7:0] c_adr_resp2    = `RESP2;
    localparam logic [7:0] c_adr_resp3    = `RESP3;
    localparam logic [7:0] c_adr_cmd_isr  = `CMD_ISR;

    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_WR_CMD    = 4'd1,
        S_WR_ARG    = 4'd2,
        S_POLL_WAIT = 4'd3,
        S_POLL_RD   = 4'd4,
        S_RD_RESP   = 4'd5,
        S_CLR_ISR   = 4'd6,
        S_DONE      = 4'd7
    } seq_state_e;

    function automatic logic [7:0] resp_addr(input logic [1:0] idx);
        logic [7:0] adr;
        case (idx)
            2'd0:    adr = c_adr_resp0;
            2'd1:    adr = c_adr_resp1;
            2'd2:    adr = c_adr_resp2;
            default: adr = c_adr_resp3;
        endcase
        return adr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/sd_wb_master_port.sv
// ============================================================================
// Module : sd_wb_master_port
// Brief  : Single-access Wishbone classic master; one transfer at a time.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sd_wb_master_port (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req,
    input  logic [7:0]  i_adr,
    input  logic        i_we,
    input  logic [31:0] i_dat,
    output logic        o_done,
    output logic [31:0] o_rdat,
    output logic [7:0]  o_wb_adr,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    output logic [3:0]  o_wb_sel,
    output logic        o_wb_we,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    input  logic        i_wb_ack
);

    logic        r_cyc;
    logic [7:0]  r_adr;
    logic [31:0] r_dat;
    logic        r_we;

    // Request is sampled only while idle, so a held request never re-launches
    // during the cycle its access completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cyc <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
            r_we  <= 1'b0;
        end else if (r_cyc) begin
            if (i_wb_ack) begin
                r_cyc <= 1'b0;
            end
        end else if (i_req) begin
            r_cyc <= 1'b1;
            r_adr <= i_adr;
            r_we  <= i_we;
            r_dat <= i_we ? i_dat : 32'h0;
        end
    end

    assign o_done   = r_cyc & i_wb_ack;
    assign o_rdat   = i_wb_dat;
    assign o_wb_adr = r_adr;
    assign o_wb_dat = r_dat;
    assign o_wb_we  = r_we;
    assign o_wb_cyc = r_cyc;
    assign o_wb_stb = r_cyc;
    assign o_wb_sel = r_cyc ? 4'hf : 4'h0;

endmodule

`default_nettype wire

// File: rtl/sd_cmd_sequencer.sv
// ============================================================================
// Module : sd_cmd_sequencer
// Brief  : Issues one SD command through the controller registers and polls.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module sd_cmd_sequencer
    import sd_cmd_sequencer_pkg::*;
#(
    parameter int POLL_GAP   = 4,
    parameter int POLL_LIMIT = 65535
) (
    input  logic                      wb_clk_i,
    input  logic                      wb_rst_ni,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [c_cmd_reg_size-1:0] req_cmd_i,
    input  logic [31:0]               req_arg_i,
    output logic                      done_o,
    output logic [c_int_cmd_size-1:0] status_o,
    output logic                      timeout_o,
    output logic [127:0]              resp_o,
    output logic [7:0]                wbm_adr_o,
    output logic [31:0]               wbm_dat_o,
    input  logic [31:0]               wbm_dat_i,
    output logic [3:0]                wbm_sel_o,
    output logic                      wbm_we_o,
    output logic                      wbm_cyc_o,
    output logic                      wbm_stb_o,
    input  logic                      wbm_ack_i
);

    localparam logic [7:0]  c_poll_gap_m1 = 8'(POLL_GAP - 1);
    localparam logic [15:0] c_poll_limit  = 16'(POLL_LIMIT);

    seq_state_e                r_state;
    seq_state_e                w_state_nxt;
    logic [c_cmd_reg_size-1:0] r_cmd;
    logic [31:0]               r_arg;
    logic [c_int_cmd_size-1:0] r_status;
    logic [127:0]              r_resp;
    logic                      r_timeout;
    logic [7:0]                r_gap_cnt;
    logic [15:0]               r_poll_cnt;
    logic [1:0]                r_resp_idx;

    logic        w_bus_req;
    logic        w_bus_we;
    logic [7:0]  w_bus_adr;
    logic [31:0] w_bus_dat;
    logic        w_bus_done;
    logic [31:0] w_bus_rdat;
    logic        w_isr_exit;
    logic        w_isr_err;
    logic        w_poll_last;
    logic [1:0]  w_resp_last;

    assign w_isr_exit  = w_bus_rdat[c_int_cmd_cc] | w_bus_rdat[c_int_cmd_ei];
    assign w_isr_err   = w_bus_rdat[c_int_cmd_ei];
    assign w_poll_last = (r_poll_cnt + 16'd1) == c_poll_limit;
    assign w_resp_last = (r_cmd[1:0] == 2'b01) ? 2'd0 : 2'd3;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_bus_req   = 1'b0;
        w_bus_we    = 1'b0;
        w_bus_adr   = 8'h00;
        w_bus_dat   = 32'h0;
        case (r_state)
            S_IDLE: begin
                if (req_valid_i) w_state_nxt = S_WR_CMD;
            end
            S_WR_CMD: begin
                w_bus_req = 1'b1;
                w_bus_we  = 1'b1;
                w_bus_adr = c_adr_command;
                w_bus_dat = {{(32-c_cmd_reg_size){1'b0}}, r_cmd};
                if (w_bus_done) w_state_nxt = S_WR_ARG;
            end
            S_WR_ARG: begin
                w_bus_req = 1'b1;
                w_bus_we  = 1'b1;
                w_bus_adr = c_adr_argument;
                w_bus_dat = r_arg;
                if (w_bus_done) w_state_nxt = S_POLL_WAIT;
            end
            S_POLL_WAIT: begin
                if (r_gap_cnt == c_poll_gap_m1) w_state_nxt = S_POLL_RD;
            end
            S_POLL_RD: begin
                w_bus_req = 1'b1;
                w_bus_adr = c_adr_cmd_isr;
                // A completed or errored command wins over the poll limit.
                if (w_bus_done) begin
                    if (w_isr_exit) begin
                        w_state_nxt = (w_isr_err || r_cmd[1:0] == 2'b00) ? S_CLR_ISR : S_RD_RESP;
                    end else if (w_poll_last) begin
                        w_state_nxt = S_CLR_ISR;
                    end else begin
                        w_state_nxt = S_POLL_WAIT;
                    end
                end
            end
            S_RD_RESP: begin
                w_bus_req = 1'b1;
                w_bus_adr = resp_addr(r_resp_idx);
                if (w_bus_done && r_resp_idx == w_resp_last) w_state_nxt = S_CLR_ISR;
            end
            S_CLR_ISR: begin
                w_bus_req = 1'b1;
                w_bus_we  = 1'b1;
                w_bus_adr = c_adr_cmd_isr;
                if (w_bus_done) w_state_nxt = S_DONE;
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cmd      <= '0;
            r_arg      <= '0;
            r_status   <= '0;
            r_resp     <= '0;
            r_timeout  <= 1'b0;
            r_gap_cnt  <= '0;
            r_poll_cnt <= '0;
            r_resp_idx <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid_i) begin
                        r_cmd      <= req_cmd_i;
                        r_arg      <= req_arg_i;
                        r_status   <= '0;
                        r_resp     <= '0;
                        r_timeout  <= 1'b0;
                        r_gap_cnt  <= '0;
                        r_poll_cnt <= '0;
                        r_resp_idx <= '0;
                    end
                end
                S_POLL_WAIT: begin
                    r_gap_cnt <= r_gap_cnt + 8'd1;
                end
                S_POLL_RD: begin
                    if (w_bus_done) begin
                        r_gap_cnt  <= '0;
                        r_poll_cnt <= r_poll_cnt + 16'd1;
                        if (w_bus_rdat[c_int_cmd_size-1:0] != '0) begin
                            r_status <= w_bus_rdat[c_int_cmd_size-1:0];
                        end
                        if (!w_isr_exit && w_poll_last) r_timeout <= 1'b1;
                    end
                end
                S_RD_RESP: begin
                    if (w_bus_done) begin
                        r_resp[{r_resp_idx, 5'b0} +: 32] <= w_bus_rdat;
                        r_resp_idx                       <= r_resp_idx + 2'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    sd_wb_master_port u_wb_port (
        .clk      (wb_clk_i),
        .rst_n    (wb_rst_ni),
        .i_req    (w_bus_req),
        .i_adr    (w_bus_adr),
        .i_we     (w_bus_we),
        .i_dat    (w_bus_dat),
        .o_done   (w_bus_done),
        .o_rdat   (w_bus_rdat),
        .o_wb_adr (wbm_adr_o),
        .o_wb_dat (wbm_dat_o),
        .i_wb_dat (wbm_dat_i),
        .o_wb_sel (wbm_sel_o),
        .o_wb_we  (wbm_we_o),
        .o_wb_cyc (wbm_cyc_o),
        .o_wb_stb (wbm_stb_o),
        .i_wb_ack (wbm_ack_i)
    );

    assign req_ready_o = (r_state == S_IDLE);
    assign done_o      = (r_state == S_DONE);
    assign status_o    = r_status;
    assign timeout_o   = r_timeout;
    assign resp_o      = r_resp;

endmodule

`default_nettype wire
